ingress_port_buffer: RTL and testbench
======================================

Name: ingress_port_buffer

Overview:
- Per-port ingress stage directly upstream of the shared-SRAM write path; one instance per input port.
- Accepts the unthrottled wr_sop/wr_eop/wr_vld/wr_data beat stream and buffers it store-and-forward.
- Extracts destination and priority from the first beat and releases only whole, well-formed packets downstream, each with a descriptor.
- Drops packets it cannot hold and malformed packets, because the write interface has no backpressure.

Parameters:
- data_width, 256, beat width.
- num_of_ports, 16, number of ports; dest field width PW = $clog2(num_of_ports).
- num_of_priority, 8, number of priority classes; prio field width QW = $clog2(num_of_priority).
- fifo_depth, 64, beat FIFO entries (power of 2).
- max_beats, 32, longest legal packet in beats; must be <= fifo_depth.
- desc_depth, 8, descriptor FIFO entries (power of 2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_sop  in  1  first beat of packet.
- wr_eop  in  1  last beat of packet.
- wr_vld  in  1  beat valid.
- wr_data  in  data_width  beat data.
- o_vld  out  1  output beat valid.
- o_rdy  in  1  downstream accepts beat.
- o_sop  out  1  first beat of output packet.
- o_eop  out  1  last beat of output packet.
- o_data  out  data_width  output beat.
- o_dest  out  PW  destination port; held for the whole output packet.
- o_prio  out  QW  priority; held for the whole output packet.
- o_len  out  $clog2(max_beats)+1  packet length in beats; held for the whole output packet.
- drop_pulse  out  1  one-cycle pulse per dropped or aborted packet.

Behaviour:
- Reset (async): all outputs 0; both FIFOs empty; state IDLE.
  - Pointer reset: wr_ptr = commit_ptr = rd_ptr = 0.
  - Reset mid-packet discards everything, including committed, unread packets.
- Header: dest = wr_data[PW-1:0], prio = wr_data[PW+QW-1:PW]; both taken on the sop beat. The header beat is also stored as data.
- Beat FIFO pointers:
  - Speculative wr_ptr advances on each accepted beat.
  - commit_ptr jumps to wr_ptr+1 on the accepted eop beat.
  - Abort rewinds wr_ptr to commit_ptr.
  - The read side sees only entries below commit_ptr, so it never underflows mid-packet.
- FSM:
  - IDLE:
    - vld&sop with free beat entries >= max_beats and descriptor FIFO not full: store beat, start len=1, go RECV.
    - If that beat also has eop: commit immediately and stay in IDLE.
    - vld&sop without that room: drop_pulse, go DROP; if the sop beat has eop, stay in IDLE.
    - vld without sop: ignored; no pulse.
  - RECV:
    - vld: store beat, len++.
    - eop: commit beats plus descriptor {dest,prio,len}, go IDLE.
    - Beat that would make len > max_beats: abort (rewind), drop_pulse, go DROP; if that beat has eop, go IDLE instead.
    - vld&sop (missing eop): abort the current packet, drop_pulse, then evaluate the new sop exactly as in IDLE in the same cycle.
  - DROP:
    - Discard beats until a beat with eop, then go IDLE.
    - vld&sop: leave DROP and evaluate as an IDLE sop in the same cycle.
- Output:
  - o_vld = committed beat available; o_sop/o_eop are the stored flags.
  - Descriptor fields come from the head of the descriptor FIFO.
  - Beat transfers on o_vld&o_rdy; the descriptor pops on the transfer of the eop beat.
  - o_data/o_sop/o_eop/o_dest/o_prio/o_len must hold stable while o_vld&!o_rdy.
- Latency: a packet whose eop is accepted in cycle N presents o_vld&o_sop no earlier than cycle N+1; back-to-back beats at one per cycle when o_rdy=1.
- Simultaneous read and write: allowed every cycle.
  - Free space = fifo_depth - (wr_ptr - rd_ptr), using pointers one bit wider than the address for wrap-around.
  - Space freed by a read is visible to the admission check in the next cycle.

Optional Feature:
- Macro INGRESS_STATS_EN.
- Defined: adds outputs pkt_cnt and drop_cnt, each 32 bits, saturating.
  - pkt_cnt increments on each descriptor commit.
  - drop_cnt increments with drop_pulse.
  - Both reset to 0.
- Undefined: no counters and no ports; all other behaviour is identical.

Decomposition:
- Shared package sram_ctl_pkg holds:
  - default widths: data_width, num_of_ports, num_of_priority;
  - header field offsets;
  - the descriptor struct {dest,prio,len};
  - FSM state enum IDLE/RECV/DROP.
- Sub-module: sync_fifo_commit, the beat FIFO with speculative write pointer, commit and rewind.
- The descriptor FIFO is a plain instance of the same module with commit tied to write.

Test Plan:
- Single packet: 3 beats, dest=5, prio=2, o_rdy=1 -> 3 output beats from cycle eop+1; sop on beat 0, eop on beat 2; o_dest=5, o_prio=2, o_len=3.
- Backpressure: 4-beat packet with o_rdy low for 5 cycles mid-packet -> outputs held stable; no beat lost or duplicated.
- Overflow: fill to 40 of 64 entries with o_rdy=0, then send sop -> drop_pulse once; that packet absent at output; earlier packets intact.
- Missing eop: 2 beats without eop, then a new sop packet of 1 beat (sop+eop) -> drop_pulse once; only the 1-beat packet is output, with o_len=1.
- Oversize: 33-beat packet -> drop_pulse on beat 33; no output; a following 2-beat packet passes.
- Async reset asserted mid-RECV with a committed packet pending -> all outputs 0 immediately; after release an idle beat without sop is ignored.

Source files
------------

// File: rtl/sram_ctl_pkg.sv
// Shared widths, header offsets, descriptor and FSM types
// for the ingress side of the shared-SRAM switch.
package sram_ctl_pkg;
  localparam int DATA_WIDTH = 256;
  localparam int NUM_OF_PORTS = 16;
  localparam int NUM_OF_PRIORITY = 8;
  localparam int MAX_BEATS = 32;
  localparam int PW = $clog2(NUM_OF_PORTS);
  localparam int QW = $clog2(NUM_OF_PRIORITY);
  localparam int LW = $clog2(MAX_BEATS) + 1;
  localparam int DEST_LSB = 0;
  localparam int PRIO_LSB = DEST_LSB + PW;

  typedef struct packed {
    logic [PW-1:0] dest;
    logic [QW-1:0] prio;
    logic [LW-1:0] len;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;
endpackage

// File: rtl/ingress_port_buffer_if.sv
// Beat stream in, packet stream out, and drop pulse
// of one ingress port buffer.
interface ingress_port_buffer_if
  import sram_ctl_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int num_of_ports = NUM_OF_PORTS,
  parameter int num_of_priority = NUM_OF_PRIORITY,
  parameter int max_beats = MAX_BEATS
);
  localparam int PWI = $clog2(num_of_ports);
  localparam int QWI = $clog2(num_of_priority);
  localparam int LWI = $clog2(max_beats) + 1;

  logic                  wr_sop;
  logic                  wr_eop;
  logic                  wr_vld;
  logic [data_width-1:0] wr_data;
  logic                  o_vld;
  logic                  o_rdy;
  logic                  o_sop;
  logic                  o_eop;
  logic [data_width-1:0] o_data;
  logic [PWI-1:0]        o_dest;
  logic [QWI-1:0]        o_prio;
  logic [LWI-1:0]        o_len;
  logic                  drop_pulse;

  modport master (
    output wr_sop, wr_eop, wr_vld, wr_data, o_rdy,
    input  o_vld, o_sop, o_eop, o_data,
    input  o_dest, o_prio, o_len, drop_pulse
  );

  modport slave (
    input  wr_sop, wr_eop, wr_vld, wr_data, o_rdy,
    output o_vld, o_sop, o_eop, o_data,
    output o_dest, o_prio, o_len, drop_pulse
  );
endinterface

// File: rtl/sync_fifo_commit.sv
// FIFO with speculative write pointer: the reader sees
// only committed entries; rewind discards uncommitted ones.
module sync_fifo_commit #(
  parameter int width = 8,
  parameter int depth = 64,
  localparam int AW = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             commit,
  input  logic             rewind,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      free
);
  localparam logic [AW:0] FULL = (AW+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW:0] wr_ptr;
  logic [AW:0] commit_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] base;
  logic [AW:0] wr_nxt;

  // rewind and a new write can share a cycle
  assign base = rewind ? commit_ptr : wr_ptr;
  assign wr_nxt = base + (AW+1)'(wr_en);
  assign free = FULL - (base - rd_ptr);
  assign empty = rd_ptr == commit_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      if (commit) commit_ptr <= wr_nxt;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[base[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/ingress_port_buffer.sv
// Store-and-forward ingress buffer releasing whole packets.
// INGRESS_STATS_EN adds saturating pkt_cnt/drop_cnt outputs.
module ingress_port_buffer
  import sram_ctl_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int num_of_ports = NUM_OF_PORTS,
  parameter int num_of_priority = NUM_OF_PRIORITY,
  parameter int fifo_depth = 64,
  parameter int max_beats = MAX_BEATS,
  parameter int desc_depth = 8
) (
  input  logic clk,
  input  logic rst_n,
  ingress_port_buffer_if.slave bus
`ifdef INGRESS_STATS_EN
  ,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_cnt
`endif
);
  localparam int PWL = $clog2(num_of_ports);
  localparam int QWL = $clog2(num_of_priority);
  localparam int LWL = $clog2(max_beats) + 1;
  localparam int BW = data_width + 2;
  localparam int DW = PWL + QWL + LWL;
  localparam int FAW = $clog2(fifo_depth);
  localparam int DAW = $clog2(desc_depth);

  state_t state, state_n;
  logic [PWL-1:0] dest, dest_n, hdr_dest;
  logic [QWL-1:0] prio, prio_n, hdr_prio;
  logic [LWL-1:0] len, len_n;
  logic wr_en, commit, rewind, abort;
  logic sop_hit, room, drop_q;
  logic [FAW:0] beat_free;
  logic [DAW:0] desc_free;
  logic beat_empty, desc_empty;
  logic rd_beat, rd_desc;
  logic [BW-1:0] beat_q;
  logic [DW-1:0] desc_in, desc_q;

  assign hdr_dest = bus.wr_data[DEST_LSB +: PWL];
  assign hdr_prio = bus.wr_data[DEST_LSB+PWL +: QWL];
  assign room = (32'(beat_free) >= max_beats)
             && (desc_free != '0);

  always_comb begin
    state_n = state;
    dest_n = dest;
    prio_n = prio;
    len_n = len;
    wr_en = 1'b0;
    commit = 1'b0;
    rewind = 1'b0;
    abort = 1'b0;
    sop_hit = 1'b0;
    unique case (state)
      IDLE: sop_hit = bus.wr_vld & bus.wr_sop;
      RECV: begin
        if (bus.wr_vld && bus.wr_sop) begin
          rewind = 1'b1;
          abort = 1'b1;
          sop_hit = 1'b1;
          state_n = IDLE;
        end else if (bus.wr_vld) begin
          if (len == LWL'(max_beats)) begin
            rewind = 1'b1;
            abort = 1'b1;
            state_n = bus.wr_eop ? IDLE : DROP;
          end else begin
            wr_en = 1'b1;
            len_n = len + 1'b1;
            if (bus.wr_eop) begin
              commit = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (bus.wr_vld && bus.wr_sop) sop_hit = 1'b1;
        else if (bus.wr_vld && bus.wr_eop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // a new sop is judged after any abort it caused
    if (sop_hit) begin
      if (room) begin
        wr_en = 1'b1;
        len_n = LWL'(1);
        dest_n = hdr_dest;
        prio_n = hdr_prio;
        commit = bus.wr_eop;
        state_n = bus.wr_eop ? IDLE : RECV;
      end else begin
        abort = 1'b1;
        state_n = bus.wr_eop ? IDLE : DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dest <= '0;
      prio <= '0;
      len <= '0;
      drop_q <= 1'b0;
    end else begin
      state <= state_n;
      dest <= dest_n;
      prio <= prio_n;
      len <= len_n;
      drop_q <= abort;
    end
  end

  assign desc_in = {dest_n, prio_n, len_n};

  sync_fifo_commit #(.width(BW), .depth(fifo_depth)) u_beat (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data({bus.wr_sop, bus.wr_eop, bus.wr_data}),
    .commit(commit),
    .rewind(rewind),
    .rd_en(rd_beat),
    .rd_data(beat_q),
    .empty(beat_empty),
    .free(beat_free)
  );

  sync_fifo_commit #(.width(DW), .depth(desc_depth)) u_desc (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(commit),
    .wr_data(desc_in),
    .commit(commit),
    .rewind(1'b0),
    .rd_en(rd_desc),
    .rd_data(desc_q),
    .empty(desc_empty),
    .free(desc_free)
  );

  assign bus.o_vld = !beat_empty && !desc_empty;
  assign rd_beat = bus.o_vld & bus.o_rdy;
  assign rd_desc = rd_beat & beat_q[BW-2];
  assign bus.o_sop = bus.o_vld & beat_q[BW-1];
  assign bus.o_eop = bus.o_vld & beat_q[BW-2];
  assign bus.o_data = bus.o_vld ? beat_q[data_width-1:0] : '0;
  assign bus.o_dest = bus.o_vld ? desc_q[DW-1 -: PWL] : '0;
  assign bus.o_prio = bus.o_vld ? desc_q[LWL +: QWL] : '0;
  assign bus.o_len = bus.o_vld ? desc_q[LWL-1:0] : '0;
  assign bus.drop_pulse = drop_q;

`ifdef INGRESS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
      if (drop_q && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ingress_port_buffer.sv
// Directed bench for ingress_port_buffer: single, backpressure,
// overflow, missing eop, oversize and async reset cases.
module tb_ingress_port_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int drops = 0;
  int d0;
  int n;

  logic [63:0] q_data[$];
  logic [1:0]  q_flags[$];
  logic [5:0]  q_len[$];
  logic [3:0]  q_dest[$];
  logic [2:0]  q_prio[$];

  ingress_port_buffer_if bus ();

`ifdef INGRESS_STATS_EN
  logic [31:0] pkt_cnt, drop_cnt;
`endif

  ingress_port_buffer dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef INGRESS_STATS_EN
    ,
    .pkt_cnt(pkt_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.drop_pulse) drops++;
    if (bus.o_vld && bus.o_rdy) begin
      q_data.push_back(bus.o_data[63:0]);
      q_flags.push_back({bus.o_sop, bus.o_eop});
      q_len.push_back(bus.o_len);
      q_dest.push_back(bus.o_dest);
      q_prio.push_back(bus.o_prio);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [7:0] tag,
      input int idx, input logic [3:0] d, input logic [2:0] p);
    logic [255:0] w;
    w = '0;
    w[3:0] = d;
    w[6:4] = p;
    w[15:8] = 8'(idx);
    w[63:56] = tag;
    return w;
  endfunction

  task automatic beat(input logic s, input logic e,
                      input logic [255:0] d);
    @(posedge clk);
    #1;
    bus.wr_vld = 1'b1;
    bus.wr_sop = s;
    bus.wr_eop = e;
    bus.wr_data = d;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) begin
      @(posedge clk);
      #1;
      bus.wr_vld = 1'b0;
      bus.wr_sop = 1'b0;
      bus.wr_eop = 1'b0;
    end
  endtask

  task automatic pkt(input logic [7:0] tag, input int nb,
      input logic [3:0] d, input logic [2:0] p, input bit eop_on);
    for (int i = 0; i < nb; i++)
      beat(i == 0, eop_on && (i == nb - 1), mk(tag, i, d, p));
  endtask

  task automatic clr();
    q_data.delete();
    q_flags.delete();
    q_len.delete();
    q_dest.delete();
    q_prio.delete();
  endtask

  initial begin
    bus.wr_vld = 1'b0;
    bus.wr_sop = 1'b0;
    bus.wr_eop = 1'b0;
    bus.wr_data = '0;
    bus.o_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vld", bus.o_vld, 0);
    chk("rst_drop", bus.drop_pulse, 0);
    chk("rst_len", bus.o_len, 0);
    rst_n = 1'b1;
    idle(2);

    // single 3-beat packet, dest 5 prio 2
    clr();
    pkt(8'h01, 3, 4'd5, 3'd2, 1);
    @(negedge clk);
    chk("t1_lat_pre", bus.o_vld, 0);
    idle(1);
    @(negedge clk);
    chk("t1_lat_post", {bus.o_vld, bus.o_sop}, 2'b11);
    idle(6);
    chk("t1_n", q_data.size(), 3);
    chk("t1_d0", q_data[0], 64'h0100_0000_0000_0025);
    chk("t1_d1", q_data[1], 64'h0100_0000_0000_0125);
    chk("t1_d2", q_data[2], 64'h0100_0000_0000_0225);
    chk("t1_f0", q_flags[0], 2'b10);
    chk("t1_f1", q_flags[1], 2'b00);
    chk("t1_f2", q_flags[2], 2'b01);
    chk("t1_dest", q_dest[2], 5);
    chk("t1_prio", q_prio[2], 2);
    chk("t1_len", q_len[0], 3);

    // backpressure mid-packet
    clr();
    bus.o_rdy = 1'b0;
    pkt(8'h02, 4, 4'd3, 3'd7, 1);
    idle(3);
    @(posedge clk);
    #1 bus.o_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.o_rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold", bus.o_data[63:0], 64'h0200_0000_0000_0273);
    end
    chk("t2_hold_len", bus.o_len, 4);
    @(posedge clk);
    #1 bus.o_rdy = 1'b1;
    idle(6);
    chk("t2_n", q_data.size(), 4);
    chk("t2_d0", q_data[0], 64'h0200_0000_0000_0073);
    chk("t2_d2", q_data[2], 64'h0200_0000_0000_0273);
    chk("t2_d3", q_data[3], 64'h0200_0000_0000_0373);
    chk("t2_f3", q_flags[3], 2'b01);
    chk("t2_desc", {q_dest[3], q_prio[3], q_len[3]}, {4'd3, 3'd7, 6'd4});

    // overflow: 40 of 64 entries used, next sop dropped
    clr();
    bus.o_rdy = 1'b0;
    d0 = drops;
    for (int k = 0; k < 5; k++) pkt(8'h10 + 8'(k), 8, 4'd1, 3'd0, 1);
    pkt(8'h3f, 4, 4'd9, 3'd1, 1);
    idle(3);
    chk("t3_drop", drops - d0, 1);
    bus.o_rdy = 1'b1;
    idle(50);
    chk("t3_n", q_data.size(), 40);
    n = 0;
    foreach (q_data[i]) if (q_data[i][63:56] == 8'h3f) n++;
    chk("t3_absent", n, 0);
    n = 0;
    foreach (q_flags[i]) if (q_flags[i][1]) n++;
    chk("t3_sops", n, 5);
    chk("t3_last", q_data[39], 64'h1400_0000_0000_0701);
    chk("t3_len", q_len[39], 8);

    // missing eop then a 1-beat packet
    clr();
    d0 = drops;
    pkt(8'h40, 2, 4'd2, 3'd1, 0);
    pkt(8'h41, 1, 4'd6, 3'd3, 1);
    idle(6);
    chk("t4_drop", drops - d0, 1);
    chk("t4_n", q_data.size(), 1);
    chk("t4_d0", q_data[0], 64'h4100_0000_0000_0036);
    chk("t4_f0", q_flags[0], 2'b11);
    chk("t4_len", q_len[0], 1);

    // oversize 33 beats, then a 2-beat packet
    clr();
    d0 = drops;
    for (int i = 0; i < 32; i++) beat(i == 0, 0, mk(8'h50, i, 4'd4, 3'd4));
    beat(0, 1, mk(8'h50, 32, 4'd4, 3'd4));
    @(negedge clk);
    chk("t5_early", bus.drop_pulse, 0);
    pkt(8'h51, 2, 4'd4, 3'd4, 1);
    idle(6);
    chk("t5_drop", drops - d0, 1);
    chk("t5_n", q_data.size(), 2);
    chk("t5_d1", q_data[1], 64'h5100_0000_0000_0144);
    chk("t5_len", q_len[1], 2);

    // async reset mid-RECV with a committed packet pending
    clr();
    bus.o_rdy = 1'b0;
    pkt(8'h60, 2, 4'd7, 3'd5, 1);
    pkt(8'h61, 2, 4'd7, 3'd5, 0);
    @(negedge clk);
    chk("t6_pre_vld", bus.o_vld, 1);
    #2 rst_n = 1'b0;
    bus.wr_vld = 1'b0;
    #1;
    chk("t6_vld", bus.o_vld, 0);
    chk("t6_flags", {bus.o_sop, bus.o_eop}, 2'b00);
    chk("t6_data", bus.o_data[63:0], 0);
    chk("t6_desc", {bus.o_dest, bus.o_prio, bus.o_len}, 0);
    chk("t6_drop", bus.drop_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.o_rdy = 1'b1;
    d0 = drops;
    beat(0, 1, mk(8'h70, 0, 4'd1, 3'd1));
    idle(6);
    chk("t6_ign_n", q_data.size(), 0);
    chk("t6_ign_drop", drops - d0, 0);
    chk("t6_ign_vld", bus.o_vld, 0);
`ifdef INGRESS_STATS_EN
    chk("t6_pkt_cnt", pkt_cnt, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
